vector_div_unit: RTL and testbench

VECTOR_DIV_UNIT -- requirements
Module: vector_div_unit

---
 rtl/vector_div_unit_pkg.sv | 26 ++
 rtl/vector_div_step.sv | 25 ++
 rtl/vector_div_unit.sv | 143 ++++++++++++++
 tb/tb_vector_div_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vector_div_unit_pkg.sv
// Shared vector-unit definitions: divider FSM states, divide control-bit
// layout and the integer divide funct6 encodings.
package vector_div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // vdiv_control_vector_i = {remainder_division, signed_unsigned}
  localparam int unsigned VDIV_REM_DIV_BIT = 1;
  localparam int unsigned VDIV_SIGN_BIT    = 0;

  localparam logic [1:0] VDIV_CTRL_VDIVU = 2'b11;
  localparam logic [1:0] VDIV_CTRL_VDIV  = 2'b10;
  localparam logic [1:0] VDIV_CTRL_VREMU = 2'b01;
  localparam logic [1:0] VDIV_CTRL_VREM  = 2'b00;

  localparam logic [5:0] FUNCT6_VDIVU = 6'b100000;
  localparam logic [5:0] FUNCT6_VDIV  = 6'b100001;
  localparam logic [5:0] FUNCT6_VREMU = 6'b100010;
  localparam logic [5:0] FUNCT6_VREM  = 6'b100011;

endpackage

// File: rtl/vector_div_step.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if no borrow.
module vector_div_step
  import vector_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  dividend_bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  quo_bit_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    shifted   = {rem_i, dividend_bit_i};
    diff      = shifted - {1'b0, divisor_i};
    quo_bit_o = ~diff[DATA_WIDTH];
    rem_o     = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/vector_div_unit.sv
// Iterative element divider for vdiv/vdivu/vrem/vremu: magnitude restoring
// division over DATA_WIDTH cycles, then a sign-fix cycle, then a held result.
module vector_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  kill_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            vdiv_control_vector_i,
  input  logic [DATA_WIDTH-1:0] vs2_i,
  input  logic [DATA_WIDTH-1:0] vs1_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);
  import vector_div_unit_pkg::*;

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  rem_div_q, rem_div_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;

  logic                  signed_op, a_neg, b_neg, div_zero, overflow, accept;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, step_rem;
  logic                  step_qbit;

  vector_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i          (rem_q),
    .dividend_bit_i (quo_q[DATA_WIDTH-1]),
    .divisor_i      (divisor_q),
    .rem_o          (step_rem),
    .quo_bit_o      (step_qbit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      rem_div_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      rem_div_q <= rem_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    signed_op = ~vdiv_control_vector_i[VDIV_SIGN_BIT];
    a_neg     = signed_op & vs2_i[DATA_WIDTH-1];
    b_neg     = signed_op & vs1_i[DATA_WIDTH-1];
    a_mag     = a_neg ? ('0 - vs2_i) : vs2_i;
    b_mag     = b_neg ? ('0 - vs1_i) : vs1_i;
    div_zero  = (vs1_i == '0);
    overflow  = signed_op && (vs2_i == MOST_NEG) && (vs1_i == '1);
    accept    = valid_i && ready_o && !kill_i;
  end

  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = (div_zero || overflow) ? DONE : CALC;
        CALC:    if (cnt_q == '0) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    rem_div_d = rem_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_div_d = vdiv_control_vector_i[VDIV_REM_DIV_BIT];
          if (div_zero) begin
            result_d = vdiv_control_vector_i[VDIV_REM_DIV_BIT] ? '1 : vs2_i;
          end else if (overflow) begin
            result_d = vdiv_control_vector_i[VDIV_REM_DIV_BIT] ? vs2_i : '0;
          end else begin
            // quo_q doubles as the dividend shift register; quotient bits enter at the LSB
            quo_d     = a_mag;
            rem_d     = '0;
            divisor_d = b_mag;
            cnt_d     = CNT_LAST;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[DATA_WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - CNT_W'(1);
      end
      FIX: begin
        if (rem_div_q) result_d = neg_quo_q ? ('0 - quo_q) : quo_q;
        else           result_d = neg_rem_q ? ('0 - rem_q) : rem_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == IDLE);
    valid_o  = (state_q == DONE);
    result_o = valid_o ? result_q : '0;
  end

endmodule

// File: tb/tb_vector_div_unit.sv
// Self-checking bench for vector_div_unit: vector table through a scoreboard,
// plus hand sequences for backpressure, kill and reset mid-operation.
module tb_vector_div_unit;
  localparam int unsigned W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i, kill_i, valid_i, ready_o, valid_o, ready_i;
  logic [1:0]   ctrl;
  logic [W-1:0] vs2, vs1, result_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];

  typedef struct {
    logic [1:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int unsigned  lat;
  } vec_t;

  vec_t vecs[18];

  vector_div_unit #(.DATA_WIDTH(W)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .kill_i                (kill_i),
    .valid_i               (valid_i),
    .ready_o               (ready_o),
    .vdiv_control_vector_i (ctrl),
    .vs2_i                 (vs2),
    .vs1_i                 (vs1),
    .valid_o               (valid_o),
    .ready_i               (ready_i),
    .result_o              (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every handshaken result must match the oldest expectation
  always @(negedge clk_i) begin
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result actual=%h expected=none", result_o);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        if (result_o !== e) begin
          errors++;
          $display("FAIL scoreboard actual=%h expected=%h", result_o, e);
        end
      end
    end
    if (valid_o === 1'b0) check("result_zero_when_invalid", result_o, '0);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("wait_ready", ready_o, 1'b1);
  endtask

  task automatic start_op(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    ctrl    = c;
    vs2     = a;
    vs1     = b;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 1;
    while (valid_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int unsigned lat, input string name);
    int unsigned n;
    start_op(c, a, b);
    sb.push_back(exp);
    wait_valid(n);
    check({name, "_latency"}, n, lat);
    check({name, "_result"}, result_o, exp);
    tick();
  endtask

  task automatic abort_in_calc(input bit use_rst, input string name);
    logic saw_valid;
    start_op(2'b11, 32'd1000, 32'd3);
    repeat (9) tick();
    if (use_rst) rst_i = 1'b1;
    else         kill_i = 1'b1;
    tick();
    rst_i  = 1'b0;
    kill_i = 1'b0;
    check({name, "_valid_after"}, valid_o, 1'b0);
    check({name, "_ready_after"}, ready_o, 1'b1);
    saw_valid = 1'b0;
    repeat (40) begin
      tick();
      if (valid_o !== 1'b0) saw_valid = 1'b1;
    end
    check({name, "_no_result"}, saw_valid, 1'b0);
    do_op(2'b11, 32'd9, 32'd3, 32'd3, 34, {name, "_followup"});
  endtask

  initial begin
    int unsigned n;
    rst_i   = 1'b1;
    kill_i  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    ctrl    = 2'b00;
    vs2     = '0;
    vs1     = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("reset_ready", ready_o, 1'b1);
    check("reset_valid", valid_o, 1'b0);
    check("reset_result", result_o, '0);

    vecs[0]  = '{2'b11, 32'd100,       32'd7,         32'd14,        34};
    vecs[1]  = '{2'b00, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  34};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  34};
    vecs[3]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1};
    vecs[4]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h0,         1};
    vecs[5]  = '{2'b11, 32'd5,         32'd0,         32'hFFFFFFFF,  1};
    vecs[6]  = '{2'b01, 32'd5,         32'd0,         32'd5,         1};
    vecs[7]  = '{2'b01, 32'd100,       32'd7,         32'd2,         34};
    vecs[8]  = '{2'b11, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  34};
    vecs[9]  = '{2'b10, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  34};
    vecs[10] = '{2'b00, 32'd100,       32'hFFFFFFF9,  32'd2,         34};
    vecs[11] = '{2'b00, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  34};
    vecs[12] = '{2'b10, 32'd0,         32'd5,         32'd0,         34};
    vecs[13] = '{2'b11, 32'd7,         32'd100,       32'd0,         34};
    vecs[14] = '{2'b01, 32'd7,         32'd100,       32'd7,         34};
    vecs[15] = '{2'b10, 32'h80000000,  32'd1,         32'h80000000,  34};
    vecs[16] = '{2'b00, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  1};
    vecs[17] = '{2'b11, 32'hFFFFFFFF,  32'h10000,     32'h0000FFFF,  34};

    for (int i = 0; i < 18; i++)
      do_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // Backpressure: result must hold while ready_i is low
    ready_i = 1'b0;
    start_op(2'b11, 32'd100, 32'd7);
    sb.push_back(32'd14);
    wait_valid(n);
    check("bp_latency", n, 34);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid_hold", valid_o, 1'b1);
      check("bp_result_hold", result_o, 32'd14);
      check("bp_ready_low", ready_o, 1'b0);
    end
    ready_i = 1'b1;
    tick();
    check("bp_idle_valid", valid_o, 1'b0);
    check("bp_idle_ready", ready_o, 1'b1);

    abort_in_calc(1'b0, "kill_calc");
    abort_in_calc(1'b1, "rst_calc");

    // Kill while a result is being held drops it
    ready_i = 1'b0;
    start_op(2'b11, 32'd50, 32'd5);
    wait_valid(n);
    check("kill_done_latency", n, 34);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill_done_valid", valid_o, 1'b0);
    check("kill_done_ready", ready_o, 1'b1);
    ready_i = 1'b1;

    // Kill in IDLE leaves the unit idle
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill_idle_ready", ready_o, 1'b1);
    do_op(2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34, "after_idle_kill");

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
